// File: rtl/hrm_host_pkg.sv
// hrm_host_pkg: shared types, default widths and helpers
// for the HRM host sequencer (hrm_host_ctrl, hrm_step_gen).
package hrm_host_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    O_IDLE,
    O_SEND
  } out_state_t;

  // Counters up to 32 bits wide; holds once max_v is reached.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max_v
  );
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hrm_step_gen.sv
// hrm_step_gen: single-step pulse generator for the HRM CPU.
// Ports: clk, i_rst; step_mode, step_div, step_req in;
//   tick_mask in (HRM_HOST_BREAK_EN only); step_pulse out.
module hrm_step_gen
  import hrm_host_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             step_mode,
  input  logic [DIV_W-1:0] step_div,
  input  logic             step_req,
`ifdef HRM_HOST_BREAK_EN
  input  logic             tick_mask,
`endif
  output logic             step_pulse
);

`ifndef HRM_HOST_BREAK_EN
  logic tick_mask;
  assign tick_mask = 1'b0;
`endif

  logic             req_q;
  logic             pulse_q;
  logic [DIV_W-1:0] cnt;
  logic             req_rise;
  logic             cnt_hit;
  logic             step_evt;

  always_comb begin
    req_rise = step_req && !req_q;
    cnt_hit  = (step_div != '0) && (cnt == step_div);
    step_evt = step_mode
             && (req_rise || (cnt_hit && !tick_mask));
  end

  // Counter wraps at all-ones if step_div shrinks below it;
  // a masked tick still restarts the period.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      req_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt     <= '0;
    end else begin
      req_q   <= step_req;
      pulse_q <= step_evt;
      if (!step_mode || step_evt || cnt_hit)
        cnt <= '0;
      else
        cnt <= cnt + DIV_W'(1);
    end
  end

  // Leaving stepped mode kills a pulse still in flight.
  assign step_pulse = pulse_q && step_mode && !i_rst;

endmodule

// File: rtl/hrm_host_ctrl.sv
// hrm_host_ctrl: host-side sequencer for the HRM CPU top level.
// Ports: s_* byte stream into INBOX (cpu_in_*), OUTBOX
//   (cpu_out_*) drained to m_* stream, step control
//   (cfg_step_*, step_req -> cpu_debug, cpu_nxtInstr),
//   saturating in_count/out_count. HRM_HOST_BREAK_EN adds
//   cfg_break_cnt in and sticky brk_hit out.
module hrm_host_ctrl
  import hrm_host_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             cfg_step_mode,
  input  logic [DIV_W-1:0] cfg_step_div,
  input  logic             step_req,
  output logic [7:0]       cpu_in_data,
  output logic             cpu_in_wr,
  input  logic             cpu_in_full,
  input  logic [7:0]       cpu_out_data,
  input  logic             cpu_out_empty,
  output logic             cpu_out_rd,
  output logic             cpu_debug,
  output logic             cpu_nxtInstr,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count
`ifdef HRM_HOST_BREAK_EN
  ,
  input  logic [CNT_W-1:0] cfg_break_cnt,
  output logic             brk_hit
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       in_wr_q;
  logic       dbg_q;
  logic       pop;
  logic       send;
  out_state_t o_state;
  out_state_t o_next;

  // Blocking on our own strobe gives the INBOX full flag a
  // cycle to update before the next accept.
  assign cpu_in_wr = in_wr_q && !i_rst;
  assign s_ready   = !cpu_in_full && !cpu_in_wr && !i_rst;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      in_wr_q     <= 1'b0;
      cpu_in_data <= '0;
      in_count    <= '0;
    end else begin
      in_wr_q <= s_valid && s_ready;
      if (s_valid && s_ready)
        cpu_in_data <= s_data;
      if (in_wr_q)
        in_count <= CNT_W'(sat_inc(
          32'(in_count), 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_state   <= O_IDLE;
      m_data    <= '0;
      out_count <= '0;
    end else begin
      o_state <= o_next;
      if (pop)
        m_data <= cpu_out_data;
      if (send && m_ready)
        out_count <= CNT_W'(sat_inc(
          32'(out_count), 32'(CNT_MAX)));
    end
  end

  // Head byte is latched on the same edge that pops it.
  always_comb begin
    o_next = o_state;
    pop    = 1'b0;
    send   = 1'b0;
    unique case (o_state)
      O_IDLE: begin
        if (!cpu_out_empty) begin
          pop    = 1'b1;
          o_next = O_SEND;
        end
      end
      O_SEND: begin
        send = 1'b1;
        if (m_ready)
          o_next = O_IDLE;
      end
    endcase
  end

  assign cpu_out_rd = pop && !i_rst;
  assign m_valid    = send && !i_rst;

  always_ff @(posedge clk) begin
    if (i_rst)
      dbg_q <= 1'b0;
    else
      dbg_q <= cfg_step_mode;
  end

  assign cpu_debug = dbg_q && !i_rst;

`ifdef HRM_HOST_BREAK_EN
  logic brk_q;

  always_ff @(posedge clk) begin
    if (i_rst || !cfg_step_mode)
      brk_q <= 1'b0;
    else if (cfg_break_cnt != '0
             && out_count == cfg_break_cnt)
      brk_q <= 1'b1;
  end

  assign brk_hit = brk_q && !i_rst;
`endif

  hrm_step_gen #(
    .DIV_W(DIV_W)
  ) u_step (
    .clk       (clk),
    .i_rst     (i_rst),
    .step_mode (cfg_step_mode),
    .step_div  (cfg_step_div),
    .step_req  (step_req),
`ifdef HRM_HOST_BREAK_EN
    .tick_mask (brk_q),
`endif
    .step_pulse(cpu_nxtInstr)
  );

endmodule

// File: tb/tb_hrm_host_ctrl.sv
// tb_hrm_host_ctrl: directed bench for hrm_host_ctrl with a
// small OUTBOX model and pulse/handshake monitors.
module tb_hrm_host_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        cfg_step_mode;
  logic [15:0] cfg_step_div;
  logic        step_req;
  logic [7:0]  cpu_in_data;
  logic        cpu_in_wr;
  logic        cpu_in_full;
  logic [7:0]  cpu_out_data = 8'h00;
  logic        cpu_out_empty = 1'b1;
  logic        cpu_out_rd;
  logic        cpu_debug;
  logic        cpu_nxtInstr;
  logic [15:0] in_count;
  logic [15:0] out_count;
`ifdef HRM_HOST_BREAK_EN
  logic [15:0] cfg_break_cnt;
  logic        brk_hit;
`endif

  int total = 0;
  int bad = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int nxt_pulses = 0;
  int rx_n = 0;
  logic [7:0] rx [8];
  logic [7:0] ob_mem [16];
  logic [3:0] ob_wp = 4'd0;
  logic [3:0] ob_rp = 4'd0;
  logic       rd_s;

  always #5 clk = ~clk;

  hrm_host_ctrl #(
    .DIV_W(16),
    .CNT_W(16)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .cfg_step_mode(cfg_step_mode),
    .cfg_step_div (cfg_step_div),
    .step_req     (step_req),
    .cpu_in_data  (cpu_in_data),
    .cpu_in_wr    (cpu_in_wr),
    .cpu_in_full  (cpu_in_full),
    .cpu_out_data (cpu_out_data),
    .cpu_out_empty(cpu_out_empty),
    .cpu_out_rd   (cpu_out_rd),
    .cpu_debug    (cpu_debug),
    .cpu_nxtInstr (cpu_nxtInstr),
    .in_count     (in_count),
    .out_count    (out_count)
`ifdef HRM_HOST_BREAK_EN
    ,
    .cfg_break_cnt(cfg_break_cnt),
    .brk_hit      (brk_hit)
`endif
  );

  always @(negedge clk) begin
    if (cpu_in_wr)
      wr_pulses++;
    if (cpu_nxtInstr)
      nxt_pulses++;
    if (m_valid && m_ready) begin
      rx[rx_n % 8] = m_data;
      rx_n++;
    end
  end

  // OUTBOX: pop seen in the cycle before the edge, flags
  // refreshed shortly after the edge.
  always begin
    @(negedge clk);
    rd_s = cpu_out_rd;
    @(posedge clk);
    #2;
    if (rd_s) begin
      ob_rp = ob_rp + 4'd1;
      rd_pulses++;
    end
    cpu_out_empty = (ob_rp == ob_wp);
    cpu_out_data  = ob_mem[ob_rp];
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ob_push(input logic [7:0] b);
    ob_mem[ob_wp] = b;
    ob_wp = ob_wp + 4'd1;
  endtask

  logic [7:0]  bytes [3];
  logic [63:0] hits;
  logic [63:0] exp_mask;
  int          pk [8];
  int          n0;
  int          r0;
  int          x0;

  initial begin
    bytes = '{8'h11, 8'h22, 8'h33};
    pk = '{3, 7, 11, 15, 19, 23, 27, 29};
    i_rst = 1'b1;
    s_data = 8'h00;
    s_valid = 1'b0;
    m_ready = 1'b0;
    cfg_step_mode = 1'b0;
    cfg_step_div = 16'd0;
    step_req = 1'b0;
    cpu_in_full = 1'b0;
`ifdef HRM_HOST_BREAK_EN
    cfg_break_cnt = 16'd0;
`endif
    step(3);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_in_wr", cpu_in_wr, 0);
    chk("rst_out_rd", cpu_out_rd, 0);
    chk("rst_in_cnt", in_count, 0);
    chk("rst_out_cnt", out_count, 0);
    chk("rst_debug", cpu_debug, 0);
    chk("rst_nxt", cpu_nxtInstr, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_in_data", cpu_in_data, 0);
    i_rst = 1'b0;

    // input stream, s_valid held
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = bytes[i];
      #1;
      chk("in_ready", s_ready, 1);
      step(1);
      chk("in_wr", cpu_in_wr, 1);
      chk("in_data", cpu_in_data, bytes[i]);
      chk("in_busy", s_ready, 0);
      step(1);
      chk("in_wr_low", cpu_in_wr, 0);
    end
    s_valid = 1'b0;
    chk("in_count3", in_count, 3);

    // INBOX full blocks the accept
    cpu_in_full = 1'b1;
    s_data = 8'h44;
    s_valid = 1'b1;
    #1;
    chk("full_ready", s_ready, 0);
    n0 = wr_pulses;
    step(4);
    chk("full_no_wr", wr_pulses - n0, 0);
    cpu_in_full = 1'b0;
    #1;
    chk("full_rel_ready", s_ready, 1);
    step(1);
    s_valid = 1'b0;
    chk("full_rel_wr", cpu_in_wr, 1);
    chk("full_rel_data", cpu_in_data, 8'h44);
    step(2);
    chk("in_count4", in_count, 4);
    chk("wr_pulses4", wr_pulses, 4);

    // OUTBOX drain with backpressure
    r0 = rd_pulses;
    x0 = rx_n;
    ob_push(8'h05);
    ob_push(8'hFA);
    step(2);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("out_hold_valid", m_valid, 1);
      chk("out_hold_data", m_data, 8'h05);
    end
    chk("out_one_pop", rd_pulses - r0, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 20 && (rx_n - x0) < 2; i++)
      step(1);
    step(2);
    chk("out_rx_n", rx_n - x0, 2);
    chk("out_rx0", rx[x0 % 8], 8'h05);
    chk("out_rx1", rx[(x0 + 1) % 8], 8'hFA);
    chk("out_two_pops", rd_pulses - r0, 2);
    chk("out_count2", out_count, 2);
    chk("out_idle", m_valid, 0);
    m_ready = 1'b0;

    // stepped mode: timer, coincident edge, manual edge,
    // switch to free-run
    cfg_step_div = 16'd3;
    cfg_step_mode = 1'b1;
    hits = '0;
    exp_mask = '0;
    foreach (pk[i])
      exp_mask[pk[i]] = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step(1);
      if (cpu_nxtInstr)
        hits[k] = 1'b1;
      if (k == 0)
        chk("dbg_on", cpu_debug, 1);
      if (k == 22)
        step_req = 1'b1;
      if (k == 25)
        step_req = 1'b0;
      if (k == 28)
        step_req = 1'b1;
      if (k == 31)
        step_req = 1'b0;
      if (k == 32)
        cfg_step_mode = 1'b0;
    end
    chk("step_pattern", hits, exp_mask);
    chk("dbg_off", cpu_debug, 0);

    // reset while a byte is held in O_SEND
    cfg_step_mode = 1'b1;
    ob_push(8'h77);
    step(4);
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_data", m_data, 8'h77);
    chk("pre_rst_dbg", cpu_debug, 1);
    i_rst = 1'b1;
    step(1);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_in_cnt", in_count, 0);
    chk("mid_rst_out_cnt", out_count, 0);
    chk("mid_rst_dbg", cpu_debug, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_ready", s_ready, 0);
    i_rst = 1'b0;
    cfg_step_mode = 1'b0;
    step(3);
    chk("post_rst_valid", m_valid, 0);

`ifdef HRM_HOST_BREAK_EN
    cfg_break_cnt = 16'd2;
    cfg_step_div = 16'd3;
    cfg_step_mode = 1'b1;
    m_ready = 1'b1;
    step(1);
    chk("brk_clear", brk_hit, 0);
    ob_push(8'hA1);
    ob_push(8'hA2);
    ob_push(8'hA3);
    for (int i = 0; i < 40 && brk_hit !== 1'b1; i++)
      step(1);
    chk("brk_set", brk_hit, 1);
    chk("brk_at_cnt", out_count, 2);
    step(2);
    n0 = nxt_pulses;
    step(16);
    chk("brk_no_auto", nxt_pulses - n0, 0);
    chk("brk_out_cnt", out_count, 3);
    chk("brk_sticky", brk_hit, 1);
    step_req = 1'b1;
    step(3);
    step_req = 1'b0;
    step(3);
    chk("brk_manual", nxt_pulses - n0, 1);
    cfg_step_mode = 1'b0;
    step(2);
    chk("brk_mode_clr", brk_hit, 0);
    m_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
